// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences EX/MEM loads/stores onto a handshaked word bus, stalling until ack or timeout
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [5:0]  mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        align_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          acc, is_b, is_h, sgn, mis, go, to;
    logic [3:0]    be;
    logic [31:0]   wd, lane, ext;
    logic          r_rd, r_sgn, r_b, r_h, r_to;
    logic [1:0]    r_off;

    // decode the EX/MEM access: size, signedness, alignment, lanes
    always_comb begin
        acc  = mem_read || mem_write;
        is_b = mem_read ? (mem_type == 6'b100000 || mem_type == 6'b100100) : (mem_type == 6'b101000);
        is_h = mem_read ? (mem_type == 6'b100001 || mem_type == 6'b100101) : (mem_type == 6'b101001);
        sgn  = mem_read && (mem_type == 6'b100000 || mem_type == 6'b100001);
        mis  = is_h ? addr[0] : (!is_b && addr[1:0] != 2'b00);
        go   = acc && !mis;
        be   = is_b ? (4'b0001 << addr[1:0]) : is_h ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd   = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    end

    // align and extend the returned word using the captured access shape
    always_comb begin
        lane = bus_rdata >> {r_off, 3'b000};
        ext  = r_b ? {{24{r_sgn & lane[7]}}, lane[7:0]} :
               r_h ? {{16{r_sgn & lane[15]}}, lane[15:0]} : bus_rdata;
    end

    // next state and combinational handshake outputs
    always_comb begin
        to         = (cnt == CW'(TIMEOUT - 1));
        state_nx   = (state == IDLE) ? (go ? WAIT : IDLE) :
                     (state == WAIT) ? ((bus_ack || to) ? DONE : WAIT) : IDLE;
        stall      = rst_n && (state == WAIT || (state == IDLE && go));
        align_err  = rst_n && state == IDLE && acc && mis;
        bus_req    = (state == WAIT);
        load_valid = (state == DONE) && r_rd;
        bus_err    = (state == DONE) && r_to;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // bus outputs are launched on entering WAIT and cleared on leaving it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            load_data <= '0;
            r_rd      <= 1'b0;
            r_sgn     <= 1'b0;
            r_b       <= 1'b0;
            r_h       <= 1'b0;
            r_to      <= 1'b0;
            r_off     <= '0;
        end else if (state == IDLE && go) begin
            cnt       <= '0;
            bus_we    <= !mem_read;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be;
            bus_wdata <= wd;
            r_rd      <= mem_read;
            r_sgn     <= sgn;
            r_b       <= is_b;
            r_h       <= is_h;
            r_to      <= 1'b0;
            r_off     <= addr[1:0];
        end else if (state == WAIT) begin
            cnt <= cnt + CW'(1);
            if (bus_ack || to) begin
                bus_we    <= 1'b0;
                bus_addr  <= '0;
                bus_be    <= '0;
                bus_wdata <= '0;
                r_to      <= !bus_ack;
                load_data <= (bus_ack && r_rd) ? ext : '0;
            end
        end
    end
endmodule
